// File: rtl/fir_uart_pkg.sv
// Shared constants and types for the FIR-result-to-UART path.
// The sync-byte option (FIR_SER_SYNC_BYTE_EN) uses SYNC_BYTE and the SYNC state.
package fir_uart_pkg;

    localparam int FIR_OUT_WIDTH = 38;
    localparam int FIR_OUT_BYTES = 5;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Serializer states; SYNC is only reachable when the sync byte is enabled.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        LOAD  = 3'd2,
        GUARD = 3'd3,
        WAITB = 3'd4
    } ser_state_t;

    // Number of whole bytes needed to carry a value of the given bit width.
    function automatic int bytes_for_width(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with read-first (show-ahead) output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A write into a full FIFO is ignored; a read from an empty FIFO is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Advance the pointers on accepted writes and reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fir_result_serializer.sv
// Buffers FIR filter results and sends each one to the UART transmitter as
// sign-extended bytes, least-significant byte first, via TxD_start/TxD_busy.
// Optional: define FIR_SER_SYNC_BYTE_EN to prefix every result with 8'hA5.
module fir_result_serializer
    import fir_uart_pkg::*;
#(
    parameter int OUT_WIDTH  = FIR_OUT_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OUT_WIDTH-1:0] fir_output,
    input  logic                 output_valid,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 fifo_full,
    output logic                 overflow,
    output logic                 idle
);

    localparam int NUM_BYTES = bytes_for_width(OUT_WIDTH);
    localparam int SHW       = NUM_BYTES * 8;
    localparam int IDXW      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int CW        = $clog2(FIFO_DEPTH) + 1;

    logic [OUT_WIDTH-1:0] fifo_head;
    logic                 fifo_is_full;
    logic                 fifo_is_empty;
    logic                 push;
    logic                 pop;
    logic [SHW-1:0]       head_ext;
    logic [SHW-1:0]       shreg;
    logic [IDXW-1:0]      idx;
    logic                 last_byte;
    logic                 sync_active;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;
    logic                 to_idle;
    ser_state_t           state;

    assign push      = output_valid && !fifo_is_full;
    assign pop       = (state == IDLE) && !fifo_is_empty;
    assign last_byte = (idx == IDXW'(NUM_BYTES - 1));

    sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (fir_output),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_is_full),
        .empty   (fifo_is_empty)
    );

    // Replicate the sign bit of the head result up to a whole number of bytes.
    always_comb begin
        head_ext = {SHW{fifo_head[OUT_WIDTH-1]}};
        head_ext[OUT_WIDTH-1:0] = fifo_head;
    end

`ifdef FIR_SER_SYNC_BYTE_EN
    logic sync_phase;
    assign sync_active = sync_phase;
`else
    assign sync_active = 1'b0;
`endif

    // Occupancy after this cycle's push/pop, used for the registered status flags.
    always_comb begin
        count_next = count;
        if (push && !pop) count_next = count + 1'b1;
        else if (pop && !push) count_next = count - 1'b1;
    end

    // True when the FSM will sit in IDLE next cycle with nothing left to send.
    always_comb begin
        to_idle = 1'b0;
        if (count_next == '0) begin
            if (state == IDLE && fifo_is_empty) to_idle = 1'b1;
            if (state == WAITB && !tx_busy && last_byte && !sync_active) to_idle = 1'b1;
        end
    end

    // Byte transfer FSM: pop a result, then LOAD/GUARD/WAITB once per byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            shreg    <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
`ifdef FIR_SER_SYNC_BYTE_EN
            sync_phase <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_is_empty) begin
                        shreg <= head_ext;
                        idx   <= '0;
`ifdef FIR_SER_SYNC_BYTE_EN
                        state <= SYNC;
`else
                        state <= LOAD;
`endif
                    end
                end
`ifdef FIR_SER_SYNC_BYTE_EN
                SYNC: begin
                    if (!tx_busy) begin
                        tx_data    <= SYNC_BYTE;
                        tx_start   <= 1'b1;
                        sync_phase <= 1'b1;
                        state      <= GUARD;
                    end
                end
`endif
                LOAD: begin
                    if (!tx_busy) begin
                        tx_data  <= shreg[7:0];
                        tx_start <= 1'b1;
                        state    <= GUARD;
                    end
                end
                GUARD: begin
                    state <= WAITB;
                end
                WAITB: begin
                    if (!tx_busy) begin
`ifdef FIR_SER_SYNC_BYTE_EN
                        if (sync_phase) begin
                            sync_phase <= 1'b0;
                            state      <= LOAD;
                        end else
`endif
                        if (last_byte) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx + IDXW'(1);
                            shreg <= shreg >> 8;
                            state <= LOAD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Occupancy count, sticky overflow and the registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
            idle      <= 1'b1;
        end else begin
            count     <= count_next;
            fifo_full <= (count_next == CW'(FIFO_DEPTH));
            if (output_valid && fifo_is_full) overflow <= 1'b1;
            idle      <= to_idle;
        end
    end

endmodule

// File: tb/tb_fir_result_serializer.sv
// Self-checking bench for fir_result_serializer with a simple UART transmitter
// model. Define FIR_SER_SYNC_BYTE_EN to exercise the sync-byte build.
`timescale 1ns/1ps
module tb_fir_result_serializer;

    localparam int OUT_WIDTH  = 38;
    localparam int FIFO_DEPTH = 4;
    localparam int NUM_BYTES  = (OUT_WIDTH + 7) / 8;
`ifdef FIR_SER_SYNC_BYTE_EN
    localparam int XFERS = NUM_BYTES + 1;
`else
    localparam int XFERS = NUM_BYTES;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [OUT_WIDTH-1:0] fir_output = '0;
    logic                 output_valid = 1'b0;
    logic                 tx_busy;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 fifo_full;
    logic                 overflow;
    logic                 idle;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         busy_cnt = 0;
    int         busy_len = 10;
    bit         force_busy = 1'b0;
    int         width_viol = 0;
    bit         prev_start = 1'b0;

    always #5 clk = ~clk;

    assign tx_busy = force_busy || (busy_cnt != 0);

    fir_result_serializer #(
        .OUT_WIDTH  (OUT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fir_output   (fir_output),
        .output_valid (output_valid),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .idle         (idle)
    );

    // Transmitter model: capture each started byte, then stay busy for busy_len cycles.
    always @(negedge clk) begin
        if (tx_start) begin
            got_q.push_back(tx_data);
            if (prev_start) width_viol++;
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        prev_start = tx_start;
    end

    // Watchdog so the run always ends.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference: sign-extend numerically and emit bytes LSB first.
    task automatic expectResult(input logic [OUT_WIDTH-1:0] r);
        longint v;
        v = longint'($signed(r));
`ifdef FIR_SER_SYNC_BYTE_EN
        exp_q.push_back(8'hA5);
`endif
        for (int k = 0; k < NUM_BYTES; k++) exp_q.push_back(8'((v >>> (8 * k)) & 255));
    endtask

    task automatic applyStimulus(input logic [OUT_WIDTH-1:0] r);
        output_valid = 1'b1;
        fir_output   = r;
        tick();
        output_valid = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic waitIdle(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (idle && got_q.size() >= exp_q.size()) done = 1'b1;
        end
        if (!done) checkOutput({tag, "_idle_timeout"}, 1, 0);
    endtask

    task automatic waitBytes(input string tag, input int n, input int budget);
        bit done;
        done = (got_q.size() >= n);
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (got_q.size() >= n) done = 1'b1;
        end
        if (!done) checkOutput({tag, "_bytes_timeout"}, 1, 0);
    endtask

    task automatic compareStream(input string tag);
        int n;
        checkOutput({tag, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    function automatic logic [OUT_WIDTH-1:0] randResult();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[OUT_WIDTH-1:0];
    endfunction

    logic [OUT_WIDTH-1:0] res[8];

    initial begin
        int lat;
        int n;
        bit seen;
        $display("[TB] start, %0d transfers per result", XFERS);
        repeat (2) tick();
        checkOutput("rst_tx_start", tx_start, 0);
        checkOutput("rst_tx_data", tx_data, 8'h00);
        checkOutput("rst_fifo_full", fifo_full, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_idle", idle, 1);
        rst = 1'b1;
        tick();

        // Test 1: single positive result, also measures first-start latency.
        got_q.delete(); exp_q.delete();
        expectResult(38'h0012345678);
        output_valid = 1'b1;
        fir_output   = 38'h0012345678;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            output_valid = 1'b0;
            lat++;
            if (tx_start) seen = 1'b1;
        end
        checkOutput("t1_latency", lat, 3);
        checkOutput("t1_idle_busy", idle, 0);
        waitIdle("t1", 400);
        compareStream("t1");
        checkOutput("t1_idle_after", idle, 1);

        // Test 2: negative result, top byte must be sign-extended.
        got_q.delete(); exp_q.delete();
        expectResult(38'h3FFFFFFFFE);
        applyStimulus(38'h3FFFFFFFFE);
        waitIdle("t2", 400);
        compareStream("t2");

        // Random bursts of back-to-back results with varying transmitter pacing.
        for (int it = 0; it < 6; it++) begin
            got_q.delete(); exp_q.delete();
            busy_len = $urandom_range(1, 12);
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) res[j] = randResult();
            for (int j = 0; j < n; j++) expectResult(res[j]);
            for (int j = 0; j < n; j++) applyStimulus(res[j]);
            waitIdle($sformatf("rnd%0d", it), 2000);
            compareStream($sformatf("rnd%0d", it));
            checkOutput($sformatf("rnd%0d_ovf", it), overflow, 0);
        end
        busy_len = 10;

        // Test 4: push and pop in the same cycle at count 3.
        doReset();
        for (int j = 0; j < 6; j++) res[j] = randResult();
        for (int j = 0; j < 6; j++) expectResult(res[j]);
        force_busy = 1'b1;
        applyStimulus(res[0]);
        repeat (3) tick();
        for (int j = 1; j < 4; j++) applyStimulus(res[j]);
        checkOutput("t4_full_at3", fifo_full, 0);
        force_busy = 1'b0;
        waitBytes("t4", XFERS, 600);
        force_busy = 1'b1;
        repeat (15) tick();
        force_busy = 1'b0;
        tick();
        output_valid = 1'b1;
        fir_output   = res[4];
        force_busy   = 1'b1;
        tick();
        output_valid = 1'b0;
        checkOutput("t4_full_pushpop", fifo_full, 0);
        checkOutput("t4_ovf_pushpop", overflow, 0);
        applyStimulus(res[5]);
        checkOutput("t4_full_at4", fifo_full, 1);
        checkOutput("t4_ovf_at4", overflow, 0);
        force_busy = 1'b0;
        waitIdle("t4", 3000);
        compareStream("t4");

        // Test 3: six strobes while the transmitter is stalled.
        doReset();
        for (int j = 0; j < 7; j++) res[j] = randResult();
        for (int j = 0; j < 5; j++) expectResult(res[j]);
        force_busy = 1'b1;
        applyStimulus(res[0]);
        repeat (3) tick();
        output_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fir_output = res[i + 1];
            tick();
            checkOutput($sformatf("t3_full_%0d", i), fifo_full, (i >= 3) ? 1 : 0);
            checkOutput($sformatf("t3_ovf_%0d", i), overflow, (i >= 4) ? 1 : 0);
        end
        output_valid = 1'b0;
        force_busy = 1'b0;
        waitIdle("t3", 3000);
        compareStream("t3");
        checkOutput("t3_ovf_sticky", overflow, 1);

        // Test 5: reset in the middle of a result with two more queued.
        got_q.delete(); exp_q.delete();
        for (int j = 0; j < 3; j++) res[j] = randResult();
        expectResult(res[0]);
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        force_busy = 1'b1;
        applyStimulus(res[0]);
        repeat (3) tick();
        applyStimulus(res[1]);
        applyStimulus(res[2]);
        force_busy = 1'b0;
        waitBytes("t5", 2, 200);
        rst = 1'b0;
        #1;
        checkOutput("t5_tx_start", tx_start, 0);
        checkOutput("t5_idle", idle, 1);
        checkOutput("t5_overflow", overflow, 0);
        checkOutput("t5_fifo_full", fifo_full, 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (300) tick();
        compareStream("t5");
        checkOutput("t5_idle_after", idle, 1);

        checkOutput("start_pulse_width", width_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
